// File: rtl/parity_frame_rx_pkg.sv
// Shared types and helpers for the parity frame path.
// Used by both the receive checker and the transmit side.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Parity bit that makes XOR(data, bit) equal to odd.
    function automatic logic calc_parity(
        input logic [15:0] data,
        input logic odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_err_cnt.sv
// Saturating count of errored frames for parity_frame_rx.
// Only built when PARITY_FRAME_RX_ERR_CNT_EN is defined.
module parity_frame_err_cnt
    import parity_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'h00;
        end else if (inc && cnt != ERR_CNT_MAX) begin
            cnt <= cnt + 8'h01;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Strobe-qualified serial receiver/checker for parity frames.
// Optional error counter: define PARITY_FRAME_RX_ERR_CNT_EN.
module parity_frame_rx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              frame_err,
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    output logic              busy,
    output logic [7:0]        err_cnt
`else
    output logic              busy
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    rx_state_t         state;
    rx_state_t         state_nx;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              run_par;
    logic              par_bad;
    logic              stop_lat;
    logic              pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bit_valid) begin
            unique case (state)
                IDLE: begin
                    if (sin == START_BIT) begin
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    if (bit_cnt == LAST) begin
                        state_nx = PARITY;
                    end
                end
                PARITY: state_nx = STOP;
                STOP:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            run_par  <= 1'b0;
            par_bad  <= 1'b0;
            stop_lat <= 1'b1;
            pend     <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (bit_valid) begin
                unique case (state)
                    IDLE: begin
                        if (sin == START_BIT) begin
                            bit_cnt <= '0;
                            run_par <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg[bit_cnt] <= sin;
                        run_par        <= run_par ^ sin;
                        if (bit_cnt != LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        par_bad <= ((run_par ^ sin) != ODD_PARITY);
                    end
                    STOP: begin
                        stop_lat <= sin;
                        pend     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Delivery lags the stop sample by one edge; shreg is not
    // touched until the next frame's first data bit, so it is
    // still intact here even for a back-to-back start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= pend;
            if (pend) begin
                dout       <= shreg;
                parity_err <= par_bad;
                frame_err  <= (stop_lat != STOP_BIT);
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    logic err_inc;

    assign err_inc = pend & (par_bad | (stop_lat != STOP_BIT));

    parity_frame_err_cnt u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx (DATA_W=8, even parity).
// Define PARITY_FRAME_RX_ERR_CNT_EN to also exercise err_cnt.
module tb_parity_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       bit_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    parity_frame_rx #(
        .DATA_W     (8),
        .ODD_PARITY (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .bit_valid  (bit_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .parity_err (parity_err),
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        .frame_err  (frame_err),
        .busy       (busy),
        .err_cnt    (err_cnt)
`else
        .frame_err  (frame_err),
        .busy       (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_cnt = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                check("frame_err", 32'(frame_err), 32'(e.fe));
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
                check("err_cnt", 32'(err_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
            bit_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        sin = b;
        bit_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bit_valid = 1'b0;
            sin = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int gap,
                              input logic pe, input logic fe);
        exp_t e;
        if ((pe || fe) && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(s, gap);
    endtask

    initial begin
        rst_n = 1'b0;
        sin = 1'b1;
        bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
`endif
        rst_n = 1'b1;
        idle(2);

        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle(4);
        send_frame(8'h07, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        idle(4);
        send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(4);

        send_frame(8'h3C, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        idle(8);
        check("hold_dout", 32'(dout), 32'h3C);
        check("hold_valid", 32'(dout_valid), 32'h0);
        check("hold_busy", 32'(busy), 32'h0);

        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_dout", 32'(dout), 32'h0);
        exp_cnt = 8'h00;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'hFF, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        idle(4);

        send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h80, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle(4);

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        for (int k = 0; k < 300; k++) begin
            send_frame(8'h07, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        end
        idle(4);
        check("err_cnt_sat", 32'(err_cnt), 32'hFF);
`endif

        begin
            int budget;
            budget = 200;
            while (exp_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
        end
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
